// File: rtl/codificador_4b5b_pkg.sv
// ---------------------------------------------------------------------------
// codificador_4b5b_pkg
// Shared types and constants for the 4B/5B line encoder (FDDI / 100BASE-X).
//   nibble_t   : 4-bit data nibble {a,b,c,d}, bit 3 = a
//   symbol_t   : 5-bit line symbol {m1..m5}, bit 4 = m1 (first on the line)
//   IDLE_CODE  : symbol presented after reset (4B/5B IDLE, 11111)
//   enc4b5b()  : the 16-entry data code table
// ---------------------------------------------------------------------------
package codificador_4b5b_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [4:0] symbol_t;

    localparam symbol_t IDLE_CODE = 5'b11111;

    // Every data code has at most one leading zero and at most two trailing
    // zeros, which bounds run length on the line once serialized.
    function automatic symbol_t enc4b5b(input nibble_t n);
        symbol_t s;
        case (n)
            4'h0: s = 5'b11110;
            4'h1: s = 5'b01001;
            4'h2: s = 5'b10100;
            4'h3: s = 5'b10101;
            4'h4: s = 5'b01010;
            4'h5: s = 5'b01011;
            4'h6: s = 5'b01110;
            4'h7: s = 5'b01111;
            4'h8: s = 5'b10010;
            4'h9: s = 5'b10011;
            4'hA: s = 5'b10110;
            4'hB: s = 5'b10111;
            4'hC: s = 5'b11010;
            4'hD: s = 5'b11011;
            4'hE: s = 5'b11100;
            4'hF: s = 5'b11101;
            default: s = IDLE_CODE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/codificador_4b5b_lut.sv
// ---------------------------------------------------------------------------
// enc4b5b_lut
// Purely combinational nibble -> 4B/5B symbol table.
//   i_nibble : 4-bit data nibble
//   o_symbol : 5-bit encoded symbol
// ---------------------------------------------------------------------------
module enc4b5b_lut
    import codificador_4b5b_pkg::*;
(
    input  nibble_t i_nibble,
    output symbol_t o_symbol
);

    assign o_symbol = enc4b5b(i_nibble);

endmodule

// File: rtl/codificador_4b5b.sv
// ---------------------------------------------------------------------------
// codificador_4b5b
// 4-bit to 5-bit line encoder with a registered output symbol.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high; forces IDLE symbol, clears valid
//   a,b,c,d    : nibble bits 3..0 (a = MSB)
//   ready      : load strobe; nibble captured when high at a clock edge
//   m1..m5     : symbol bits 4..0 (m1 = MSB, first bit on the line)
//   valid      : high for one cycle after each accepted nibble
// Outputs come straight from flops; latency is one clock.
// ---------------------------------------------------------------------------
module codificador_4b5b
    import codificador_4b5b_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic ready,
    output logic m1,
    output logic m2,
    output logic m3,
    output logic m4,
    output logic m5,
    output logic valid
);

    nibble_t w_nibble;
    symbol_t w_symbol;
    symbol_t r_symbol;
    logic    r_valid;

    assign w_nibble = {a, b, c, d};

    enc4b5b_lut u_lut (
        .i_nibble (w_nibble),
        .o_symbol (w_symbol)
    );

    // The symbol holds between strobes so the serializer always has a
    // stable code; valid marks only the cycle after a fresh capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_symbol <= IDLE_CODE;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= ready;
            if (ready) begin
                r_symbol <= w_symbol;
            end
        end
    end

    assign {m1, m2, m3, m4, m5} = r_symbol;
    assign valid                = r_valid;

endmodule

// File: tb/tb_codificador_4b5b.sv
module tb_codificador_4b5b;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic ready = 1'b0;
    logic m1, m2, m3, m4, m5, valid;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];
    logic [4:0] tbl [16];

    always #5 clk = ~clk;

    codificador_4b5b dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .ready (ready),
        .m1    (m1),
        .m2    (m2),
        .m3    (m3),
        .m4    (m4),
        .m5    (m5),
        .valid (valid)
    );

    function automatic logic [4:0] sym();
        return {m1, m2, m3, m4, m5};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lead_zeros(input logic [4:0] s);
        int n = 0;
        for (int i = 4; i >= 0; i--) begin
            if (s[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int trail_zeros(input logic [4:0] s);
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) break;
            n++;
        end
        return n;
    endfunction

    // Drive one cycle: set inputs, expect a capture if ready, wait past the edge.
    task automatic step(input logic rdy, input logic [3:0] n);
        {a, b, c, d} = n;
        ready = rdy;
        if (rdy && !reset) exp_q.push_back(tbl[n]);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid cycle must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {27'd0, sym()}, 32'h0);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("scoreboard_symbol", {27'd0, sym()}, {27'd0, e});
                    chk("lead_zeros_le1", {31'd0, lead_zeros(sym()) <= 1}, 32'd1);
                    chk("trail_zeros_le2", {31'd0, trail_zeros(sym()) <= 2}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] held;
        tbl = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                5'b01010, 5'b01011, 5'b01110, 5'b01111,
                5'b10010, 5'b10011, 5'b10110, 5'b10111,
                5'b11010, 5'b11011, 5'b11100, 5'b11101};

        // Reset pulse before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("reset_async_sym", {27'd0, sym()}, 32'h1F);
        chk("reset_async_valid", {31'd0, valid}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'(i + 3));
            chk("post_reset_idle_sym", {27'd0, sym()}, 32'h1F);
            chk("post_reset_idle_valid", {31'd0, valid}, 32'd0);
        end

        // Exhaustive sweep, back-to-back.
        for (int n = 0; n < 16; n++) begin
            step(1'b1, 4'(n));
            chk("sweep_sym", {27'd0, sym()}, {27'd0, tbl[n]});
            chk("sweep_valid", {31'd0, valid}, 32'd1);
        end

        // Hold while data toggles.
        step(1'b1, 4'h5);
        chk("hold_load_sym", {27'd0, sym()}, 32'b01011);
        chk("hold_load_valid", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)));
            chk("hold_sym", {27'd0, sym()}, 32'b01011);
            chk("hold_valid", {31'd0, valid}, 32'd0);
        end

        // Strobe alternation.
        step(1'b1, 4'h2);
        chk("alt_sym0", {27'd0, sym()}, 32'b10100);
        chk("alt_valid0", {31'd0, valid}, 32'd1);
        step(1'b0, 4'h8);
        chk("alt_sym1", {27'd0, sym()}, 32'b10100);
        chk("alt_valid1", {31'd0, valid}, 32'd0);
        step(1'b1, 4'h8);
        chk("alt_sym2", {27'd0, sym()}, 32'b10010);
        chk("alt_valid2", {31'd0, valid}, 32'd1);
        step(1'b0, 4'h2);
        chk("alt_sym3", {27'd0, sym()}, 32'b10010);
        chk("alt_valid3", {31'd0, valid}, 32'd0);

        // Async reset mid-stream.
        step(1'b1, 4'hC);
        chk("midrst_load_sym", {27'd0, sym()}, 32'b11010);
        ready = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_async_sym", {27'd0, sym()}, 32'h1F);
        chk("midrst_async_valid", {31'd0, valid}, 32'd0);
        step(1'b1, 4'h3);
        chk("midrst_blocked_sym", {27'd0, sym()}, 32'h1F);
        chk("midrst_blocked_valid", {31'd0, valid}, 32'd0);
        ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'h3);
        chk("post_midrst_sym", {27'd0, sym()}, 32'b10101);

        // Randomized traffic.
        held = 5'b10101;
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [3:0] n;
            r = ($urandom_range(0, 3) != 0);
            n = 4'($urandom_range(0, 15));
            if (r) held = tbl[n];
            step(r, n);
            chk("rand_sym", {27'd0, sym()}, {27'd0, held});
            chk("rand_valid", {31'd0, valid}, {31'd0, r});
        end

        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/codificador_4b5b.md
# codificador_4b5b

4-bit to 5-bit line encoder (FDDI/100BASE-X 4B/5B table) that converts a nibble on inputs a..d into a 5-bit symbol on outputs m1..m5. A nibble is captured when the ready strobe is high on a clock edge, and the encoded symbol is registered. The block sits between a nibble-wide data source and a 5-bit symbol serializer/line driver.

## Interface
- IDLE_CODE, 5'b11111, symbol driven on m1..m5 after reset (4B/5B IDLE).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  1  nibble bit 3 (MSB).
- b  input  1  nibble bit 2.
- c  input  1  nibble bit 1.
- d  input  1  nibble bit 0 (LSB).
- ready  input  1  load strobe; nibble {a,b,c,d} is sampled when high at a clk edge.
- m1  output  1  symbol bit 4 (MSB, first bit on the line).
- m2  output  1  symbol bit 3.
- m3  output  1  symbol bit 2.
- m4  output  1  symbol bit 1.
- m5  output  1  symbol bit 0 (LSB).
- valid  output  1  high for one cycle after each accepted nibble.

## Operation
- Nibble N = {a,b,c,d}; symbol S = {m1,m2,m3,m4,m5}.
- Encoding (hex nibble -> symbol): 0->11110, 1->01001, 2->10100, 3->10101, 4->01010, 5->01011, 6->01110, 7->01111, 8->10010, 9->10011, A->10110, B->10111, C->11010, D->11011, E->11100, F->11101.
- Mapping is a pure combinational function of N; the table covers all 16 values, with no default or illegal case.
- ready=1 at an edge: S register loads encode(N); valid register loads 1.
- ready=0 at an edge: S holds its previous value; valid loads 0.
- Back-to-back ready=1 accepts a new nibble every cycle; there is no backpressure.
- Every valid symbol has at most one leading zero and at most two trailing zeros. The bench checks this property for all 16 codes.

## Timing
- Reset (async assert, any time): S = IDLE_CODE (11111) and valid = 0 immediately, independent of clk. Reset held high overrides ready.
- Reset deassert: first capture occurs at the first rising clk edge with reset=0 and ready=1.
- Latency: one cycle. A nibble sampled at edge k appears on m1..m5 with valid=1 after edge k. It stays there until the next accepted nibble or reset.
- Reset asserted mid-stream: an in-flight symbol is discarded and the outputs return to IDLE_CODE.
- Inputs a..d and ready must be stable around the sampling edge. Changes between edges have no effect.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.

## Structure
- Shared package holds: IDLE_CODE constant, a 4-bit nibble typedef, a 5-bit symbol typedef, and the 16-entry encode function/table so the decoder and bench reuse it.
- One natural sub-module: enc4b5b_lut, a purely combinational nibble->symbol table. The top holds only the S/valid registers and the ready/reset control.

## Test plan
- Reset: pulse reset=1 with no clk edge -> S=11111 and valid=0 at once. After deassert with ready=0 for 3 cycles -> S stays 11111.
- Exhaustive sweep: N=0..F with ready=1 on consecutive edges -> after each edge S equals the table entry (e.g. 0->11110, 7->01111, 9->10011, F->11101) and valid=1 every cycle.
- Hold: load N=5 (S=01011), then ready=0 for 4 cycles while a..d toggle -> S stays 01011 and valid=0 from the 2nd cycle.
- Strobe alternation: ready toggles 1,0,1,0 with N=2 then N=8 -> S=10100 then 10010, valid pattern 1,0,1,0.
- Async reset mid-stream: after N=C is loaded (S=11010), assert reset between edges -> S=11111 and valid=0 before the next edge. ready=1 with N=3 at the edge while reset is high -> no load.
- Property check: for every emitted symbol, count of leading zeros ≤1 and trailing zeros ≤2.
